// File: rtl/rv_mem_pkg.sv
// Shared definitions for the unified memory port: access lengths,
// arbiter state encoding and transaction owner ids.
package rv_mem_pkg;

  localparam logic [1:0] MEM_LEN_NONE = 2'b00;
  localparam logic [1:0] MEM_LEN_BYTE = 2'b01;
  localparam logic [1:0] MEM_LEN_HALF = 2'b10;
  localparam logic [1:0] MEM_LEN_WORD = 2'b11;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2,
    ARB_RESP = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts WAIT cycles without a memory response; o_expired flags the cycle
// whose increment would reach TIMEOUT_CYCLES.
module mem_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != CNT_W'(TIMEOUT_CYCLES))) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Not gated by i_enable so the arbiter can use it to decide i_enable's effect.
  assign o_expired = (r_count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store,
// one transaction at a time, with a data-streak limit and response timeout.
module mem_port_arbiter
  import rv_mem_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MAX_DM_STREAK  = 4,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int STREAK_W      = $clog2(MAX_DM_STREAK + 1)
) (
  input  logic                SYS_clk,
  input  logic                SYS_reset,
  input  logic                IF_req,
  input  logic [ADDR_W-1:0]   IF_addr,
  output logic                IF_done,
  output logic                IF_err,
  output logic [DATA_W-1:0]   IF_rdata,
  input  logic                DM_req,
  input  logic                DM_we,
  input  logic [1:0]          DM_length,
  input  logic                DM_signed,
  input  logic [ADDR_W-1:0]   DM_addr,
  input  logic [DATA_W-1:0]   DM_wdata,
  output logic                DM_done,
  output logic                DM_err,
  output logic [DATA_W-1:0]   DM_rdata,
  output logic                MEM_req,
  output logic                MEM_we,
  output logic [1:0]          MEM_length,
  output logic                MEM_signed,
  output logic [ADDR_W-1:0]   MEM_addr,
  output logic [DATA_W-1:0]   MEM_wdata,
  input  logic                MEM_ready,
  input  logic                MEM_rvalid,
  input  logic [DATA_W-1:0]   MEM_rdata,
  output logic [1:0]          DBG_state,
  output logic [STREAK_W-1:0] DBG_streak
);

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  owner_t              r_owner;
  logic [STREAK_W-1:0] r_streak;

  logic w_grant;
  logic w_grant_dm;
  logic w_tmo_clear;
  logic w_tmo_en;
  logic w_tmo_expired;
  logic w_capture;
  logic w_resp_err;
  logic w_resp_enter;
  logic w_resp_dm;

  mem_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk    (SYS_clk),
    .i_reset  (SYS_reset),
    .i_clear  (w_tmo_clear),
    .i_enable (w_tmo_en),
    .o_expired(w_tmo_expired)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_grant_dm  = 1'b0;
    w_tmo_clear = 1'b0;
    w_tmo_en    = 1'b0;
    w_capture   = 1'b0;
    w_resp_err  = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (IF_req || DM_req) begin
          w_grant = 1'b1;
          // Data wins unless fetch has been passed over MAX_DM_STREAK times.
          w_grant_dm = DM_req && !(IF_req && (r_streak == STREAK_W'(MAX_DM_STREAK)));
          if (w_grant_dm && (DM_length == MEM_LEN_NONE)) begin
            w_state_nxt = ARB_RESP;
          end else begin
            w_state_nxt = ARB_REQ;
            w_tmo_clear = 1'b1;
          end
        end
      end
      ARB_REQ: begin
        if (MEM_ready) w_state_nxt = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (MEM_rvalid) begin
          w_capture   = 1'b1;
          w_state_nxt = ARB_RESP;
        end else begin
          w_tmo_en = 1'b1;
          if (w_tmo_expired) begin
            w_resp_err  = 1'b1;
            w_state_nxt = ARB_RESP;
          end
        end
      end
      ARB_RESP: w_state_nxt = ARB_IDLE;
      default:  w_state_nxt = ARB_IDLE;
    endcase
  end

  assign w_resp_enter = (r_state != ARB_RESP) && (w_state_nxt == ARB_RESP);
  assign w_resp_dm    = (r_state == ARB_IDLE) ? w_grant_dm : (r_owner == OWN_DM);

  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      r_state    <= ARB_IDLE;
      r_owner    <= OWN_IF;
      r_streak   <= '0;
      IF_done    <= 1'b0;
      IF_err     <= 1'b0;
      IF_rdata   <= '0;
      DM_done    <= 1'b0;
      DM_err     <= 1'b0;
      DM_rdata   <= '0;
      MEM_req    <= 1'b0;
      MEM_we     <= 1'b0;
      MEM_length <= MEM_LEN_NONE;
      MEM_signed <= 1'b0;
      MEM_addr   <= '0;
      MEM_wdata  <= '0;
    end else begin
      r_state <= w_state_nxt;
      IF_done <= w_resp_enter && !w_resp_dm && !w_resp_err;
      IF_err  <= w_resp_enter && !w_resp_dm &&  w_resp_err;
      DM_done <= w_resp_enter &&  w_resp_dm && !w_resp_err;
      DM_err  <= w_resp_enter &&  w_resp_dm &&  w_resp_err;

      if (w_grant) begin
        MEM_req <= (w_state_nxt == ARB_REQ);
        if (w_grant_dm) begin
          r_owner    <= OWN_DM;
          r_streak   <= IF_req ? r_streak + 1'b1 : '0;
          MEM_we     <= DM_we;
          MEM_length <= DM_length;
          MEM_signed <= DM_signed;
          MEM_addr   <= DM_addr;
          MEM_wdata  <= DM_wdata;
        end else begin
          r_owner    <= OWN_IF;
          r_streak   <= '0;
          MEM_we     <= 1'b0;
          MEM_length <= MEM_LEN_WORD;
          MEM_signed <= 1'b0;
          MEM_addr   <= IF_addr;
          MEM_wdata  <= '0;
        end
      end else if ((r_state == ARB_REQ) && MEM_ready) begin
        MEM_req <= 1'b0;
      end

      if (w_capture) begin
        if (r_owner == OWN_DM) DM_rdata <= MEM_rdata;
        else                   IF_rdata <= MEM_rdata;
      end
    end
  end

  assign DBG_state  = r_state;
  assign DBG_streak = r_streak;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: requester agents, a memory
// responder model, per-port expected queues and a vector table.
module tb_mem_port_arbiter;

  localparam int TMO = 8;

  typedef struct { logic [31:0] addr; logic err; } if_op_t;
  typedef struct {
    logic we; logic [1:0] len; logic sgn;
    logic [31:0] addr; logic [31:0] wdata; logic err;
  } dm_op_t;
  typedef struct {
    logic we; logic [1:0] len; logic sgn; logic [31:0] addr; logic [31:0] wdata;
  } acc_t;
  typedef struct {
    logic is_dm; logic we; logic [1:0] len; logic sgn;
    logic [31:0] addr; logic [31:0] wdata; int stall; int lat;
    logic [3:0] exp_ctrl; logic [31:0] exp_addr; logic [31:0] exp_wdata;
  } vec_t;

  logic        clk = 1'b0;
  logic        SYS_reset = 1'b1;
  logic        IF_req, IF_done, IF_err;
  logic [31:0] IF_addr, IF_rdata;
  logic        DM_req, DM_we, DM_signed, DM_done, DM_err;
  logic [1:0]  DM_length;
  logic [31:0] DM_addr, DM_wdata, DM_rdata;
  logic        MEM_req, MEM_we, MEM_signed, MEM_ready, MEM_rvalid;
  logic [1:0]  MEM_length;
  logic [31:0] MEM_addr, MEM_wdata, MEM_rdata;
  logic [1:0]  DBG_state;
  logic [2:0]  DBG_streak;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [32:0] if_exp_q[$];
  logic [32:0] dm_exp_q[$];
  if_op_t      if_todo[$];
  dm_op_t      dm_todo[$];
  acc_t        mem_log[$];
  logic [31:0] exp_dm_hold;
  int if_issue_cyc, dm_issue_cyc, last_if_lat, last_dm_lat;
  int mem_stall = 0, mem_lat = 0, kick_req = 0;
  bit mem_mute = 0;

  wire [136:0] w_all_out = {IF_done, IF_err, IF_rdata, DM_done, DM_err, DM_rdata, MEM_req,
                            MEM_we, MEM_length, MEM_signed, MEM_addr, MEM_wdata};

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_DM_STREAK(4), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .SYS_clk(clk), .SYS_reset(SYS_reset),
    .IF_req(IF_req), .IF_addr(IF_addr), .IF_done(IF_done), .IF_err(IF_err), .IF_rdata(IF_rdata),
    .DM_req(DM_req), .DM_we(DM_we), .DM_length(DM_length), .DM_signed(DM_signed),
    .DM_addr(DM_addr), .DM_wdata(DM_wdata), .DM_done(DM_done), .DM_err(DM_err),
    .DM_rdata(DM_rdata),
    .MEM_req(MEM_req), .MEM_we(MEM_we), .MEM_length(MEM_length), .MEM_signed(MEM_signed),
    .MEM_addr(MEM_addr), .MEM_wdata(MEM_wdata), .MEM_ready(MEM_ready),
    .MEM_rvalid(MEM_rvalid), .MEM_rdata(MEM_rdata),
    .DBG_state(DBG_state), .DBG_streak(DBG_streak)
  );

  // clock / cycle counter / watchdog
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a + 32'h3;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // memory responder: stalls MEM_ready mem_stall cycles, answers mem_lat cycles after accept
  initial begin : mem_model
    int stall_cnt, resp_wait, kick_done;
    bit resp_pending;
    logic [31:0] acc_addr;
    stall_cnt = 0; resp_wait = 0; kick_done = 0; resp_pending = 0; acc_addr = '0;
    MEM_ready = 0; MEM_rvalid = 0; MEM_rdata = '0;
    forever begin
      @(negedge clk);
      MEM_rvalid = 0;
      MEM_ready  = 0;
      if (SYS_reset) begin
        resp_pending = 0;
        stall_cnt = 0;
      end else begin
        if (kick_req != kick_done) begin
          MEM_rvalid = 1; MEM_rdata = 32'hCAFE_F00D; kick_done = kick_req;
        end
        if (resp_pending) begin
          if (resp_wait == 0) begin
            MEM_rvalid = !mem_mute; MEM_rdata = mem_word(acc_addr); resp_pending = 0;
          end else resp_wait--;
        end
        if (MEM_req) begin
          if (stall_cnt < mem_stall) stall_cnt++;
          else begin
            MEM_ready = 1; stall_cnt = 0; resp_pending = 1; resp_wait = mem_lat;
            acc_addr = MEM_addr;
            mem_log.push_back('{we: MEM_we, len: MEM_length, sgn: MEM_signed,
                                addr: MEM_addr, wdata: MEM_wdata});
          end
        end
      end
    end
  end

  // fetch driver: holds a request until done/err, then issues the next one
  initial begin : if_agent
    if_op_t op;
    IF_req = 0; IF_addr = '0;
    forever begin
      @(negedge clk);
      if (SYS_reset) begin
        IF_req = 0; if_todo.delete(); if_exp_q.delete();
      end else begin
        if (IF_req && (IF_done || IF_err)) IF_req = 0;
        if (!IF_req && if_todo.size() > 0) begin
          op = if_todo.pop_front();
          IF_req = 1; IF_addr = op.addr;
          if_exp_q.push_back(op.err ? {1'b1, 32'h0} : {1'b0, mem_word(op.addr)});
          if_issue_cyc = cyc;
        end
      end
    end
  end

  // load/store driver
  initial begin : dm_agent
    dm_op_t op;
    DM_req = 0; DM_we = 0; DM_length = 0; DM_signed = 0; DM_addr = '0; DM_wdata = '0;
    exp_dm_hold = '0;
    forever begin
      @(negedge clk);
      if (SYS_reset) begin
        DM_req = 0; dm_todo.delete(); dm_exp_q.delete(); exp_dm_hold = '0;
      end else begin
        if (DM_req && (DM_done || DM_err)) DM_req = 0;
        if (!DM_req && dm_todo.size() > 0) begin
          op = dm_todo.pop_front();
          DM_req = 1; DM_we = op.we; DM_length = op.len; DM_signed = op.sgn;
          DM_addr = op.addr; DM_wdata = op.wdata;
          if (op.err) dm_exp_q.push_back({1'b1, 32'h0});
          else if (op.len == 2'b00) dm_exp_q.push_back({1'b0, exp_dm_hold});
          else begin
            exp_dm_hold = mem_word(op.addr);
            dm_exp_q.push_back({1'b0, exp_dm_hold});
          end
          dm_issue_cyc = cyc;
        end
      end
    end
  end

  // scoreboard: pop and compare on every completion pulse
  initial begin : monitor
    logic [32:0] e;
    forever begin
      @(posedge clk); #1;
      if (IF_done || IF_err) begin
        last_if_lat = cyc - if_issue_cyc;
        if (if_exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_if: got unexpected pulse err=%0b, want none", IF_err);
        end else begin
          e = if_exp_q.pop_front();
          check("sb_if", 64'({IF_err, IF_err ? 32'h0 : IF_rdata}), 64'(e));
        end
        check("if_pulse_excl", 64'(IF_done & IF_err), 64'd0);
      end
      if (DM_done || DM_err) begin
        last_dm_lat = cyc - dm_issue_cyc;
        if (dm_exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_dm: got unexpected pulse err=%0b, want none", DM_err);
        end else begin
          e = dm_exp_q.pop_front();
          check("sb_dm", 64'({DM_err, DM_err ? 32'h0 : DM_rdata}), 64'(e));
        end
        check("dm_pulse_excl", 64'(DM_done & DM_err), 64'd0);
      end
    end
  end

  task automatic wait_quiet(input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (n < 300 && !(if_todo.size() == 0 && dm_todo.size() == 0 &&
                            !IF_req && !DM_req && DBG_state == 2'd0));
    check({"quiet_", name}, 64'(n < 300), 64'd1);
  endtask

  vec_t vecs[6];
  logic [9:0] exp_order;

  initial begin : main
    int base, req_cyc, unstable, wait_cnt, done_cnt, err_cnt, n, pulses, nonzero;

    vecs[0] = '{is_dm:0, we:0, len:2'b11, sgn:0, addr:32'h0000_0010, wdata:32'h0, stall:0, lat:0,
                exp_ctrl:4'b0110, exp_addr:32'h0000_0010, exp_wdata:32'h0};
    vecs[1] = '{is_dm:1, we:0, len:2'b11, sgn:0, addr:32'h0000_0200, wdata:32'h0, stall:0, lat:1,
                exp_ctrl:4'b0110, exp_addr:32'h0000_0200, exp_wdata:32'h0};
    vecs[2] = '{is_dm:1, we:0, len:2'b01, sgn:1, addr:32'h0000_0201, wdata:32'h1111, stall:0, lat:2,
                exp_ctrl:4'b0011, exp_addr:32'h0000_0201, exp_wdata:32'h1111};
    vecs[3] = '{is_dm:1, we:1, len:2'b10, sgn:0, addr:32'h0000_0302, wdata:32'hBEEF, stall:1, lat:0,
                exp_ctrl:4'b1100, exp_addr:32'h0000_0302, exp_wdata:32'hBEEF};
    vecs[4] = '{is_dm:0, we:0, len:2'b11, sgn:0, addr:32'hFFFF_FFFC, wdata:32'h0, stall:2, lat:3,
                exp_ctrl:4'b0110, exp_addr:32'hFFFF_FFFC, exp_wdata:32'h0};
    vecs[5] = '{is_dm:1, we:1, len:2'b11, sgn:1, addr:32'h0000_0400, wdata:32'hDEAD_BEEF, stall:0, lat:0,
                exp_ctrl:4'b1111, exp_addr:32'h0000_0400, exp_wdata:32'hDEAD_BEEF};
    exp_order = 10'b0111101111;  // bit i = 1 when grant i goes to data

    // reset state
    SYS_reset = 1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 64'(|w_all_out), 64'd0);
    check("reset_state", 64'(DBG_state), 64'd0);
    check("reset_streak", 64'(DBG_streak), 64'd0);
    @(negedge clk);
    SYS_reset = 0;
    @(posedge clk); #1;

    // fetch only: done in the 4th cycle with the memory word
    base = mem_log.size();
    if_todo.push_back('{addr: 32'h0000_0010, err: 1'b0});
    wait_quiet("fetch");
    check("fetch_latency", 64'(last_if_lat), 64'd3);
    check("fetch_rdata", 64'(IF_rdata), 64'h13);
    check("fetch_accesses", 64'(mem_log.size() - base), 64'd1);
    if (mem_log.size() > base) begin
      check("fetch_mem_addr", 64'(mem_log[base].addr), 64'h10);
      check("fetch_mem_len", 64'(mem_log[base].len), 64'd3);
    end

    // both requesters pending continuously
    base = mem_log.size();
    for (int i = 0; i < 3; i++) if_todo.push_back('{addr: 32'h1000 + 4 * i, err: 1'b0});
    for (int i = 0; i < 9; i++)
      dm_todo.push_back('{we: 0, len: 2'b11, sgn: 0, addr: 32'h2000 + 4 * i, wdata: 0, err: 0});
    wait_quiet("arb");
    check("arb_accesses", 64'(mem_log.size() - base), 64'd12);
    for (int i = 0; i < 10; i++)
      if (mem_log.size() > base + i)
        check($sformatf("arb_grant_%0d", i), 64'(mem_log[base + i].addr[13]), 64'(exp_order[i]));

    // table-driven single transactions
    for (int v = 0; v < 6; v++) begin
      mem_stall = vecs[v].stall;
      mem_lat   = vecs[v].lat;
      base = mem_log.size();
      if (vecs[v].is_dm)
        dm_todo.push_back('{we: vecs[v].we, len: vecs[v].len, sgn: vecs[v].sgn,
                            addr: vecs[v].addr, wdata: vecs[v].wdata, err: 0});
      else
        if_todo.push_back('{addr: vecs[v].addr, err: 1'b0});
      wait_quiet($sformatf("vec%0d", v));
      check($sformatf("vec%0d_count", v), 64'(mem_log.size() - base), 64'd1);
      if (mem_log.size() > base) begin
        check($sformatf("vec%0d_ctrl", v),
              64'({mem_log[base].we, mem_log[base].len, mem_log[base].sgn}), 64'(vecs[v].exp_ctrl));
        check($sformatf("vec%0d_addr", v), 64'(mem_log[base].addr), 64'(vecs[v].exp_addr));
        check($sformatf("vec%0d_wdata", v), 64'(mem_log[base].wdata), 64'(vecs[v].exp_wdata));
      end
    end

    // store with MEM_ready low for 3 cycles: request held 4 cycles, fields stable
    mem_stall = 3; mem_lat = 0;
    req_cyc = 0; unstable = 0;
    dm_todo.push_back('{we: 1, len: 2'b01, sgn: 0, addr: 32'h103, wdata: 32'hAB, err: 0});
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (MEM_req) begin
        req_cyc++;
        if ({MEM_we, MEM_length, MEM_signed, MEM_addr, MEM_wdata} !== {1'b1, 2'b01, 1'b0, 32'h103, 32'hAB})
          unstable++;
      end
    end
    wait_quiet("store");
    check("store_req_cycles", 64'(req_cyc), 64'd4);
    check("store_unstable", 64'(unstable), 64'd0);
    mem_stall = 0;

    // timeout: no response ever
    mem_mute = 1;
    wait_cnt = 0; done_cnt = 0; err_cnt = 0;
    dm_todo.push_back('{we: 0, len: 2'b11, sgn: 0, addr: 32'h500, wdata: 0, err: 1});
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (DBG_state == 2'd2) wait_cnt++;
      if (DM_done) done_cnt++;
      if (DM_err) err_cnt++;
    end
    check("tmo_wait_cycles", 64'(wait_cnt), 64'(TMO));
    check("tmo_err_pulses", 64'(err_cnt), 64'd1);
    check("tmo_done_pulses", 64'(done_cnt), 64'd0);
    check("tmo_idle", 64'(DBG_state), 64'd0);
    mem_mute = 0;
    if_todo.push_back('{addr: 32'h600, err: 1'b0});
    wait_quiet("after_tmo");
    check("after_tmo_latency", 64'(last_if_lat), 64'd3);

    // zero-length data access completes without touching memory
    base = mem_log.size();
    dm_todo.push_back('{we: 0, len: 2'b00, sgn: 0, addr: 32'h700, wdata: 0, err: 0});
    wait_quiet("len0");
    check("len0_latency", 64'(last_dm_lat), 64'd1);
    check("len0_accesses", 64'(mem_log.size() - base), 64'd0);

    // reset while waiting for a response, late response afterwards
    mem_mute = 1;
    if_todo.push_back('{addr: 32'h800, err: 1'b0});
    dm_todo.push_back('{we: 0, len: 2'b11, sgn: 0, addr: 32'h900, wdata: 0, err: 0});
    n = 0;
    do begin @(posedge clk); #1; n++; end while (n < 20 && DBG_state != 2'd2);
    check("rst_reach_wait", 64'(DBG_state), 64'd2);
    check("rst_owner_addr", 64'(MEM_addr), 64'h900);
    check("rst_streak_before", 64'(DBG_streak), 64'd1);
    @(negedge clk);
    SYS_reset = 1;
    repeat (2) @(negedge clk);
    SYS_reset = 0;
    kick_req++;
    pulses = 0; nonzero = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (IF_done || IF_err || DM_done || DM_err) pulses++;
      if (|w_all_out) nonzero++;
    end
    check("rst_pulses", 64'(pulses), 64'd0);
    check("rst_outputs", 64'(nonzero), 64'd0);
    check("rst_state", 64'(DBG_state), 64'd0);
    check("rst_streak", 64'(DBG_streak), 64'd0);
    mem_mute = 0;

    check("sb_drained", 64'(if_exp_q.size() + dm_exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port unified memory between the instruction-fetch requester and the load/store requester of RSICV_CPU, so the core can run from one RAM instead of separate instruction and data memories. The block grants one transaction at a time and drives the memory-side request/accept/response handshake. It returns read data and a completion pulse to the owner, and enforces a starvation limit and a response timeout. It sits between the core (fetch stage and load/store path) and the memory macro.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_DM_STREAK, 4, maximum consecutive data grants while fetch is waiting
- TIMEOUT_CYCLES, 255, maximum WAIT cycles before abort (≥2)

- SYS_clk  in  1  single clock, all logic on rising edge
- SYS_reset  in  1  synchronous, active-high reset
- IF_req  in  1  fetch request; held with IF_addr until IF_done or IF_err
- IF_addr  in  ADDR_W  fetch address (word access, unsigned)
- IF_done  out  1  one-cycle pulse; IF_rdata valid this cycle
- IF_err  out  1  one-cycle pulse; fetch aborted by timeout
- IF_rdata  out  DATA_W  fetched instruction
- DM_req  in  1  data request; held with all DM_* until DM_done or DM_err
- DM_we  in  1  1 = store, 0 = load
- DM_length  in  2  01 byte, 10 half, 11 word; 00 is completed without memory access
- DM_signed  in  1  sign-extend load
- DM_addr  in  ADDR_W  data address
- DM_wdata  in  DATA_W  store data
- DM_done  out  1  one-cycle pulse; DM_rdata valid this cycle (loads)
- DM_err  out  1  one-cycle pulse; data access aborted
- DM_rdata  out  DATA_W  load result
- MEM_req  out  1  memory request; held until accepted
- MEM_we, MEM_length, MEM_signed, MEM_addr, MEM_wdata  out  1/2/1/ADDR_W/DATA_W  registered copy of the granted request
- MEM_ready  in  1  memory accepts request when MEM_req && MEM_ready at an edge
- MEM_rvalid  in  1  completion (reads and writes), one cycle
- MEM_rdata  in  DATA_W  read data, valid with MEM_rvalid

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - If no request is pending, stay in IDLE.
  - If a request is pending, arbitrate, latch the winner's fields into the MEM_* registers and the owner bit, then go to REQ.
  - DM_req with DM_length==00 is granted and goes straight to RESP with no MEM_req.
- Arbitration:
  - Data has priority over fetch.
  - A streak counter counts consecutive data grants made while IF_req is high.
  - When the counter equals MAX_DM_STREAK and both requesters are pending, fetch wins.
  - The counter clears on any fetch grant and whenever IF_req is low at grant time.
- REQ: MEM_req=1. On MEM_ready go to WAIT. MEM_rvalid is ignored in REQ.
- WAIT: MEM_req=0.
  - On MEM_rvalid: capture MEM_rdata into the owner's rdata register and go to RESP.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT_CYCLES, go to RESP with the error flag set.
- RESP:
  - Pulse the owner's done (or err) for exactly one cycle, then go to IDLE.
  - The rdata register holds its value until the next capture.
- The timeout counter clears on entry to REQ. REQ itself has no timeout.
- The non-owner requester is never acknowledged; it may assert or drop its request freely.
- The load length/sign encoding is passed through unchanged; the memory performs the extension.
- Reset (including mid-transaction):
  - FSM returns to IDLE; all outputs, the streak counter and the timeout counter go to 0.
  - The transaction in flight is dropped with no done/err.
  - Late MEM_rvalid while in IDLE is ignored.

## Timing
- Request high at edge t (IDLE) → MEM_req high from cycle t+1.
- MEM_ready at edge t+1 (zero-wait) → WAIT from t+2.
- MEM_rvalid at edge t+k → done pulse in cycle t+k+1 → IDLE at t+k+2.
- Minimum turnaround: 4 cycles from request to done pulse with MEM_rvalid one cycle after acceptance. New grant possible in the IDLE cycle following RESP.
- DM_length==00 path: done pulse 2 cycles after the request is sampled.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Simultaneous MEM_rvalid and timeout expiry: the response wins (done, not err).

## Structure
- Shared package rv_mem_pkg holds:
  - length constants MEM_LEN_NONE/BYTE/HALF/WORD (00/01/10/11), also used by DATA_PATH;
  - arbiter state encoding;
  - owner encoding OWN_IF/OWN_DM.
- One natural sub-module: mem_timeout_counter (clear, enable, expired), sized $clog2(TIMEOUT_CYCLES+1).

## Test plan
- Fetch only: IF_req, addr 0x0000_0010, MEM_ready=1, MEM_rvalid one cycle after acceptance with 0x0000_0013 → IF_done in the 4th cycle with IF_rdata=0x0000_0013, MEM_addr=0x10, MEM_length=11.
- Both requesters pending continuously, MAX_DM_STREAK=4 → grant order DM,DM,DM,DM,IF,DM,DM,DM,DM,IF.
- Store: DM_we=1, DM_length=01, addr 0x103, wdata 0xAB, MEM_ready low for 3 cycles → MEM_req held 4 cycles with stable fields, then DM_done after MEM_rvalid.
- Timeout: MEM_rvalid never asserted, TIMEOUT_CYCLES=8 → DM_err pulse once, no DM_done, FSM back in IDLE, next IF_req served normally.
- SYS_reset asserted in WAIT, then MEM_rvalid arrives after reset → no done/err pulse, all outputs 0, streak counter 0.
- DM_length=00 request → DM_done 2 cycles later, MEM_req never asserted.
